simple_data_mem: RTL and testbench

- Parametrised, clocked successor to the combinational word-addressed instruction memory.
- Single-port data memory with valid/ready request and response channels, byte-lane write strobes and programmable read latency.
- Reports misaligned and out-of-range accesses.
- Sits between the CPU load/store stage and local storage. One transaction in flight at a time.

---
 rtl/simple_data_mem.sv | 149 ++++++++++++++
 tb/tb_simple_data_mem.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_data_mem.sv
// Single-port word memory with valid/ready request and response channels and byte-lane writes.
// Latency: resp_valid rises RD_LATENCY cycles after the request handshake edge (reads and writes).
// Backpressure: one transaction in flight; req_ready stays low until the response is taken by resp_ready.
module simple_data_mem #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF   = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 3;
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'((1 << OFF) - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
    localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(RD_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] rdata;
    } resp_t;

    function automatic logic [DATA_W-1:0] boot_word(input logic [IDX_W-1:0] idx);
        logic [DATA_W-1:0] w;
        w = '0;
        case (32'(idx))
            0:       w = DATA_W'(10);
            1:       w = DATA_W'(20);
            2:       w = DATA_W'(99);
            3:       w = DATA_W'(123);
            default: w = '0;
        endcase
        return w;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    resp_t              resp_q, resp_d;

    logic [ADDR_W-1:0]  word_full;
    logic [IDX_W-1:0]   word_idx;
    logic [IDX_W-1:0]   safe_idx;
    logic               misaligned;
    logic               out_of_range;
    logic               acc_err;
    logic               accept;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  rd_word;
    logic [DATA_W-1:0]  wr_word;

    // Address decode; an erroring address never reaches the array index.
    assign word_full    = req_addr >> OFF;
    assign word_idx     = word_full[IDX_W-1:0];
    assign misaligned   = |(req_addr & LANE_MASK);
    assign out_of_range = word_full >= DEPTH_A;
    assign acc_err      = misaligned | out_of_range;
    assign safe_idx     = acc_err ? '0 : word_idx;
    assign accept       = req_valid & req_ready;

    // The array stores contents XORed with the boot image, so the all-zero
    // power-up state of unreset storage reads back as the boot image.
    assign rd_word = mem_q[safe_idx] ^ boot_word(safe_idx);

    always_comb begin
        wr_word = rd_word;
        for (int i = 0; i < BE_W; i++) begin
            if (req_be[i]) begin
                wr_word[8*i +: 8] = req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && req_we && !acc_err) begin
            mem_q[safe_idx] <= wr_word ^ boot_word(safe_idx);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        resp_d     = resp_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    resp_d.err   = acc_err;
                    resp_d.rdata = (acc_err || req_we) ? '0 : rd_word;
                    if (RD_LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                    resp_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    assign resp_rdata = resp_q.rdata;
    assign resp_err   = resp_q.err;

endmodule

// File: tb/tb_simple_data_mem.sv
// Bench for simple_data_mem: three instances (32b/lat1, 32b/lat3, 64b/depth8/lat1),
// table vectors, hand-written corner sequences and randomized traffic against a word-array model.
module tb_simple_data_mem;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_n, req_valid, req_we, resp_ready;
    logic [2:0]  req_ready, resp_valid, resp_err;
    logic [31:0] req_addr  [3];
    logic [63:0] req_wdata [3];
    logic [7:0]  req_be    [3];
    logic [31:0] rd0, rd1;
    logic [63:0] rd2;
    logic [63:0] resp_rdata [3];

    always_comb begin
        resp_rdata[0] = {32'h0, rd0};
        resp_rdata[1] = {32'h0, rd1};
        resp_rdata[2] = rd2;
    end

    simple_data_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .RD_LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0][31:0]),
        .req_be(req_be[0][3:0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(rd0), .resp_err(resp_err[0]));

    simple_data_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .RD_LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1][31:0]),
        .req_be(req_be[1][3:0]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(rd1), .resp_err(resp_err[1]));

    simple_data_mem #(.DATA_W(64), .ADDR_W(32), .DEPTH(8), .RD_LATENCY(1)) u_w64 (
        .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .req_be(req_be[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_rdata(rd2), .resp_err(resp_err[2]));

    int dw      [3] = '{32, 32, 64};
    int depth   [3] = '{16, 16, 8};
    int lat_exp [3] = '{1, 3, 1};

    int checks   = 0;
    int failures = 0;

    logic [63:0] model [3][16];

    typedef struct {
        int          d;
        bit          we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [63:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs [19];

    logic [63:0] rd, erd;
    logic        er, eerr;
    int          lat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out waiting on the DUT", name);
    endtask

    task automatic model_init();
        for (int d = 0; d < 3; d++) begin
            for (int w = 0; w < 16; w++) model[d][w] = 64'h0;
            model[d][0] = 64'd10;
            model[d][1] = 64'd20;
            model[d][2] = 64'd99;
            model[d][3] = 64'd123;
        end
    endtask

    // Expected response for one access, applying a write to the model.
    task automatic model_access(input int d, input bit we, input logic [31:0] a,
                                input logic [63:0] wd, input logic [7:0] be,
                                output logic [63:0] exp_rd, output logic exp_err);
        int unsigned nb, idx;
        nb      = dw[d] / 8;
        idx     = a / nb;
        exp_err = (a % nb != 0) || (idx >= depth[d]);
        exp_rd  = 64'h0;
        if (!exp_err) begin
            if (!we) exp_rd = model[d][idx];
            else
                for (int i = 0; i < int'(nb); i++)
                    if (be[i]) model[d][idx][8*i +: 8] = wd[8*i +: 8];
        end
    endtask

    // One full transaction; during stall cycles resp_ready is held low and
    // stray request pulses are issued that must be ignored.
    task automatic txn(input int d, input bit we, input logic [31:0] a,
                       input logic [63:0] wd, input logic [7:0] be, input int stall,
                       output logic [63:0] rdata, output logic err, output int latency);
        int n;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_be[d]    = be;
        resp_ready[d] = 1'b0;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) timeout("req_ready");
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_we[d]    = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = {$urandom, $urandom};
        req_be[d]    = 8'($urandom);
        latency = 1;
        @(negedge clk);
        while (resp_valid[d] !== 1'b1 && latency < 20) begin
            @(negedge clk);
            latency++;
        end
        if (latency >= 20) timeout("resp_valid");
        rdata = resp_rdata[d];
        err   = resp_err[d];
        for (int k = 0; k < stall; k++) begin
            req_valid[d] = 1'($urandom_range(0, 1));
            req_we[d]    = 1'b1;
            req_addr[d]  = 32'h0;
            req_wdata[d] = {$urandom, $urandom};
            req_be[d]    = 8'hFF;
            @(negedge clk);
            check("stall_resp_valid", {63'h0, resp_valid[d]}, 64'h1);
            check("stall_rdata_stable", resp_rdata[d], rdata);
            check("stall_err_stable", {63'h0, resp_err[d]}, {63'h0, err});
            check("stall_req_ready", {63'h0, req_ready[d]}, 64'h0);
        end
        req_valid[d]  = 1'b0;
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[d] = 1'b0;
        @(negedge clk);
        check("post_resp_valid", {63'h0, resp_valid[d]}, 64'h0);
        check("post_req_ready", {63'h0, req_ready[d]}, 64'h1);
    endtask

    task automatic run_random(input int count);
        int          d, stall;
        int unsigned nb, idx;
        bit          we;
        logic [31:0] a;
        logic [63:0] wd, xrd, ard;
        logic [7:0]  be;
        logic        xerr, aerr;
        int          alat;
        for (int t = 0; t < count; t++) begin
            d   = $urandom_range(0, 2);
            nb  = dw[d] / 8;
            idx = $urandom_range(0, depth[d] + 1);
            a   = idx * nb;
            if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, nb - 1);
            if ($urandom_range(0, 15) == 0) a[31] = 1'b1;
            we    = 1'($urandom);
            wd    = {$urandom, $urandom};
            be    = 8'($urandom);
            stall = $urandom_range(0, 2);
            model_access(d, we, a, wd, be, xrd, xerr);
            txn(d, we, a, wd, be, stall, ard, aerr, alat);
            check($sformatf("rnd%0d_rdata", t), ard, xrd);
            check($sformatf("rnd%0d_err", t), {63'h0, aerr}, {63'h0, xerr});
            check($sformatf("rnd%0d_latency", t), 64'(alat), 64'(lat_exp[d]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 3'b000;
        req_valid  = 3'b000;
        req_we     = 3'b000;
        resp_ready = 3'b000;
        for (int d = 0; d < 3; d++) begin
            req_addr[d]  = 32'h0;
            req_wdata[d] = 64'h0;
            req_be[d]    = 8'h0;
        end
        model_init();

        vecs[0]  = '{0, 1'b0, 32'h00, 64'h0,                  8'h00, 64'd10,                  1'b0};
        vecs[1]  = '{0, 1'b0, 32'h04, 64'h0,                  8'h00, 64'd20,                  1'b0};
        vecs[2]  = '{0, 1'b0, 32'h08, 64'h0,                  8'h00, 64'd99,                  1'b0};
        vecs[3]  = '{0, 1'b0, 32'h0C, 64'h0,                  8'h00, 64'd123,                 1'b0};
        vecs[4]  = '{0, 1'b1, 32'h04, 64'hAABBCCDD,           8'h05, 64'h0,                   1'b0};
        vecs[5]  = '{0, 1'b0, 32'h04, 64'h0,                  8'h00, 64'h00BB00DD,            1'b0};
        vecs[6]  = '{0, 1'b0, 32'h06, 64'h0,                  8'h00, 64'h0,                   1'b1};
        vecs[7]  = '{0, 1'b0, 32'h40, 64'h0,                  8'h00, 64'h0,                   1'b1};
        vecs[8]  = '{0, 1'b1, 32'h40, 64'hFFFFFFFF,           8'h0F, 64'h0,                   1'b1};
        vecs[9]  = '{0, 1'b1, 32'h3C, 64'h12345678,           8'h00, 64'h0,                   1'b0};
        vecs[10] = '{0, 1'b0, 32'h3C, 64'h0,                  8'h00, 64'h0,                   1'b0};
        vecs[11] = '{0, 1'b0, 32'h00, 64'h0,                  8'h00, 64'd10,                  1'b0};
        vecs[12] = '{1, 1'b0, 32'h04, 64'h0,                  8'h00, 64'd20,                  1'b0};
        vecs[13] = '{1, 1'b0, 32'h41, 64'h0,                  8'h00, 64'h0,                   1'b1};
        vecs[14] = '{2, 1'b1, 32'h38, 64'h0123456789ABCDEF,   8'hFF, 64'h0,                   1'b0};
        vecs[15] = '{2, 1'b0, 32'h38, 64'h0,                  8'h00, 64'h0123456789ABCDEF,    1'b0};
        vecs[16] = '{2, 1'b0, 32'h3C, 64'h0,                  8'h00, 64'h0,                   1'b1};
        vecs[17] = '{2, 1'b0, 32'h40, 64'h0,                  8'h00, 64'h0,                   1'b1};
        vecs[18] = '{2, 1'b0, 32'h08, 64'h0,                  8'h00, 64'd20,                  1'b0};

        // Reset state, both while held and after release.
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("in_reset_req_ready%0d", d), {63'h0, req_ready[d]}, 64'h1);
            check($sformatf("in_reset_resp_valid%0d", d), {63'h0, resp_valid[d]}, 64'h0);
        end
        repeat (3) @(negedge clk);
        rst_n = 3'b111;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_req_ready%0d", d), {63'h0, req_ready[d]}, 64'h1);
            check($sformatf("reset_resp_valid%0d", d), {63'h0, resp_valid[d]}, 64'h0);
            check($sformatf("reset_rdata%0d", d), resp_rdata[d], 64'h0);
            check($sformatf("reset_err%0d", d), {63'h0, resp_err[d]}, 64'h0);
        end

        for (int i = 0; i < 19; i++) begin
            model_access(vecs[i].d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, erd, eerr);
            txn(vecs[i].d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                (i % 3 == 0) ? 2 : 0, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), {63'h0, er}, {63'h0, vecs[i].exp_err});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(lat_exp[vecs[i].d]));
        end

        // Backpressure on the latency-3 instance: 5 stalled cycles with stray requests.
        model_access(1, 1'b0, 32'h0C, 64'h0, 8'h0, erd, eerr);
        txn(1, 1'b0, 32'h0C, 64'h0, 8'h0, 5, rd, er, lat);
        check("bp_rdata", rd, 64'd123);
        check("bp_err", {63'h0, er}, 64'h0);
        check("bp_latency", 64'(lat), 64'd3);
        model_access(1, 1'b0, 32'h00, 64'h0, 8'h0, erd, eerr);
        txn(1, 1'b0, 32'h00, 64'h0, 8'h0, 0, rd, er, lat);
        check("bp_word0_untouched", rd, 64'd10);

        // Reset while the write waits for its response.
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'h08;
        req_wdata[1] = 64'h11111111;
        req_be[1]    = 8'h0F;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("wait_resp_valid", {63'h0, resp_valid[1]}, 64'h0);
        check("wait_req_ready", {63'h0, req_ready[1]}, 64'h0);
        rst_n[1] = 1'b0;
        #1;
        check("rst_mid_resp_valid", {63'h0, resp_valid[1]}, 64'h0);
        check("rst_mid_req_ready", {63'h0, req_ready[1]}, 64'h1);
        @(negedge clk);
        rst_n[1] = 1'b1;
        model[1][2] = 64'h11111111;
        repeat (4) @(negedge clk);
        check("rst_dropped_resp", {63'h0, resp_valid[1]}, 64'h0);
        model_access(1, 1'b0, 32'h08, 64'h0, 8'h0, erd, eerr);
        txn(1, 1'b0, 32'h08, 64'h0, 8'h0, 0, rd, er, lat);
        check("rst_write_kept", rd, 64'h11111111);

        // Every word of the first instance against the model.
        for (int w = 0; w < 16; w++) begin
            model_access(0, 1'b0, 32'(w * 4), 64'h0, 8'h0, erd, eerr);
            txn(0, 1'b0, 32'(w * 4), 64'h0, 8'h0, 0, rd, er, lat);
            check($sformatf("sweep_word%0d", w), rd, erd);
        end

        run_random(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
